// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, FSM states and digit decode for the RPN controller
package calc_pkg;

    localparam logic [4:0] KEY_DIGIT_1 = 5'b10000;
    localparam logic [4:0] KEY_DIGIT_4 = 5'b10001;
    localparam logic [4:0] KEY_DIGIT_7 = 5'b10010;
    localparam logic [4:0] KEY_DIGIT_0 = 5'b10011;
    localparam logic [4:0] KEY_DIGIT_2 = 5'b10100;
    localparam logic [4:0] KEY_DIGIT_5 = 5'b10101;
    localparam logic [4:0] KEY_DIGIT_8 = 5'b10110;
    localparam logic [4:0] KEY_DIGIT_3 = 5'b11000;
    localparam logic [4:0] KEY_DIGIT_6 = 5'b11001;
    localparam logic [4:0] KEY_DIGIT_9 = 5'b11010;

    localparam logic [4:0] KEY_PUSH = 5'b11100;
    localparam logic [4:0] KEY_ADD  = 5'b11101;
    localparam logic [4:0] KEY_SUB  = 5'b11110;
    localparam logic [4:0] KEY_MUL  = 5'b11111;
    localparam logic [4:0] KEY_DIV  = 5'b10111;
    localparam logic [4:0] KEY_CLR  = 5'b11011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] value;
    } digit_t;

    // Map a numpad code onto its digit value; valid is low for command codes.
    function automatic digit_t decode_digit(input logic [4:0] code);
        digit_t d;
        d.valid = 1'b1;
        d.value = 4'd0;
        case (code)
            KEY_DIGIT_0: d.value = 4'd0;
            KEY_DIGIT_1: d.value = 4'd1;
            KEY_DIGIT_2: d.value = 4'd2;
            KEY_DIGIT_3: d.value = 4'd3;
            KEY_DIGIT_4: d.value = 4'd4;
            KEY_DIGIT_5: d.value = 4'd5;
            KEY_DIGIT_6: d.value = 4'd6;
            KEY_DIGIT_7: d.value = 4'd7;
            KEY_DIGIT_8: d.value = 4'd8;
            KEY_DIGIT_9: d.value = 4'd9;
            default:     d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per cycle
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done
);
    localparam int CNTW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] rem_in, quo_in, div_in, rem_out;
    logic [WIDTH:0]   shifted, diff;
    logic             q_bit;

    // The first iteration runs on the start edge itself so the last bit lands
    // WIDTH-1 cycles later and done lines up with the controller's DIV window.
    always_comb begin
        rem_in  = start ? '0 : rem_q;
        quo_in  = start ? dividend : quo_q;
        div_in  = start ? divisor : div_q;
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {1'b0, div_in};
        q_bit   = (shifted >= {1'b0, div_in});
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            rem_d = rem_out;
            quo_d = {quo_in[WIDTH-2:0], q_bit};
            div_d = divisor;
            cnt_d = CNTW'(WIDTH - 1);
        end else if (cnt_q != '0) begin
            rem_d  = rem_out;
            quo_d  = {quo_in[WIDTH-2:0], q_bit};
            cnt_d  = cnt_q - 1'b1;
            done_d = (cnt_q == CNTW'(1));
        end
    end

    // Divider state; reset abandons any division in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/rpn_controller.sv
// rtl/rpn_controller.sv - numpad key to operand-stack transaction controller
module rpn_controller
    import calc_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    parameter  int RADIX = 10,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       pressed,
    input  logic [WIDTH-1:0] top,
    input  logic [WIDTH-1:0] next,
    input  logic [CW-1:0]    count,
    output logic             push,
    output logic             pop,
    output logic             write,
    output logic [WIDTH-1:0] new_value,
    output logic             busy,
    output logic             err
);
    localparam logic [2*WIDTH-1:0] RADIX_W = (2*WIDTH)'(RADIX);

    state_t           state_q, state_d;
    logic [4:0]       key_q, key_d;
    logic             push_q, push_d, pop_q, pop_d, write_q, write_d, err_q, err_d;
    logic [WIDTH-1:0] new_value_q, new_value_d;

    logic             key_edge, div_start, div_done, two_ops;
    logic [WIDTH-1:0] quotient;
    digit_t           dig;
    logic [WIDTH:0]   add_full;
    logic [2*WIDTH-1:0] mul_full, dig_full;

    assign key_edge = pressed[4] && (!key_q[4] || (key_q[3:0] != pressed[3:0]));
    assign dig      = decode_digit(pressed);
    assign two_ops  = (count >= CW'(2));
    assign add_full = {1'b0, next} + {1'b0, top};
    assign mul_full = {{WIDTH{1'b0}}, next} * {{WIDTH{1'b0}}, top};
    assign dig_full = {{WIDTH{1'b0}}, top} * RADIX_W + {{(2*WIDTH-4){1'b0}}, dig.value};

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (next),
        .divisor  (top),
        .quotient (quotient),
        .done     (div_done)
    );

    // Decode one key edge per press into pulses; DIV and DONE drop key edges.
    always_comb begin
        state_d     = state_q;
        key_d       = pressed;
        push_d      = 1'b0;
        pop_d       = 1'b0;
        write_d     = 1'b0;
        err_d       = err_q;
        new_value_d = new_value_q;
        div_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_edge) begin
                    if (pressed == KEY_CLR) begin
                        new_value_d = '0;
                        write_d     = 1'b1;
                        err_d       = 1'b0;
                    end else if (!err_q) begin
                        if (dig.valid) begin
                            if (count == '0 || dig_full[2*WIDTH-1:WIDTH] != '0) begin
                                err_d = 1'b1;
                            end else begin
                                new_value_d = dig_full[WIDTH-1:0];
                                write_d     = 1'b1;
                            end
                        end else begin
                            case (pressed)
                                KEY_PUSH: begin
                                    if (count == CW'(DEPTH)) err_d  = 1'b1;
                                    else                     push_d = 1'b1;
                                end
                                KEY_ADD: begin
                                    if (!two_ops || add_full[WIDTH]) begin
                                        err_d = 1'b1;
                                    end else begin
                                        new_value_d = add_full[WIDTH-1:0];
                                        pop_d       = 1'b1;
                                        write_d     = 1'b1;
                                    end
                                end
                                KEY_SUB: begin
                                    if (!two_ops || next < top) begin
                                        err_d = 1'b1;
                                    end else begin
                                        new_value_d = next - top;
                                        pop_d       = 1'b1;
                                        write_d     = 1'b1;
                                    end
                                end
                                KEY_MUL: begin
                                    if (!two_ops || mul_full[2*WIDTH-1:WIDTH] != '0) begin
                                        err_d = 1'b1;
                                    end else begin
                                        new_value_d = mul_full[WIDTH-1:0];
                                        pop_d       = 1'b1;
                                        write_d     = 1'b1;
                                    end
                                end
                                KEY_DIV: begin
                                    if (!two_ops || top == '0) begin
                                        err_d = 1'b1;
                                    end else begin
                                        div_start = 1'b1;
                                        state_d   = DIV;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            end
            DIV: begin
                if (div_done) begin
                    new_value_d = quotient;
                    pop_d       = 1'b1;
                    write_d     = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Controller state, key history and registered output pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            key_q       <= 5'b00000;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            new_value_q <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            push_q      <= push_d;
            pop_q       <= pop_d;
            write_q     <= write_d;
            err_q       <= err_d;
            new_value_q <= new_value_d;
        end
    end

    assign push      = push_q;
    assign pop       = pop_q;
    assign write     = write_q;
    assign err       = err_q;
    assign new_value = new_value_q;
    assign busy      = (state_q == DIV);

endmodule

// File: tb/tb_rpn_controller.sv
// tb/tb_rpn_controller.sv - directed self-checking bench for rpn_controller
module tb_rpn_controller;
    localparam int W  = 32;
    localparam int D  = 32;
    localparam int CW = $clog2(D) + 1;

    localparam logic [4:0] K_1   = 5'b10000;
    localparam logic [4:0] K_0   = 5'b10011;
    localparam logic [4:0] K_3   = 5'b11000;
    localparam logic [4:0] K_5   = 5'b10101;
    localparam logic [4:0] K_PSH = 5'b11100;
    localparam logic [4:0] K_ADD = 5'b11101;
    localparam logic [4:0] K_SUB = 5'b11110;
    localparam logic [4:0] K_MUL = 5'b11111;
    localparam logic [4:0] K_DIV = 5'b10111;
    localparam logic [4:0] K_CLR = 5'b11011;

    logic          clock = 1'b0;
    logic          reset;
    logic [4:0]    pressed, pressed_h;
    logic [W-1:0]  top, next, top_h, next_h;
    logic [CW-1:0] count, count_h;
    logic          push, pop, write, busy, err;
    logic          push_h, pop_h, write_h, busy_h, err_h;
    logic [W-1:0]  new_value, new_value_h;

    int total = 0;
    int bad   = 0;
    int n;
    int stray;

    always #5 clock = ~clock;

    rpn_controller #(.WIDTH(W), .DEPTH(D), .RADIX(10)) u_dut (
        .clock(clock), .reset(reset), .pressed(pressed), .top(top), .next(next),
        .count(count), .push(push), .pop(pop), .write(write),
        .new_value(new_value), .busy(busy), .err(err)
    );

    rpn_controller #(.WIDTH(W), .DEPTH(D), .RADIX(16)) u_hex (
        .clock(clock), .reset(reset), .pressed(pressed_h), .top(top_h), .next(next_h),
        .count(count_h), .push(push_h), .pop(pop_h), .write(write_h),
        .new_value(new_value_h), .busy(busy_h), .err(err_h)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [4:0] code);
        pressed = code;
        tick();
    endtask

    task automatic release_key();
        pressed = 5'b00000;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        pressed = '0; top = '0; next = '0; count = '0;
        pressed_h = '0; top_h = '0; next_h = '0; count_h = '0;
        tick(); tick();
        chk("rst_push", push, 0);
        chk("rst_pop", pop, 0);
        chk("rst_write", write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_nv", new_value, 0);
        reset = 1'b1;
        tick();

        // held digit 5 onto 12 -> single write of 125
        count = 1; top = 12;
        press(K_5);
        chk("dig_write", write, 1);
        chk("dig_nv", new_value, 125);
        n = 0;
        repeat (9) begin tick(); if (write) n++; end
        chk("dig_hold_repeat", n, 0);
        release_key();

        // digit on empty stack
        count = 0;
        press(K_0);
        chk("dig_empty_err", err, 1);
        chk("dig_empty_write", write, 0);
        release_key();
        press(K_CLR);
        chk("clr1_write", write, 1);
        chk("clr1_err", err, 0);
        release_key();

        // sub borrow then clear
        count = 2; next = 7; top = 9;
        press(K_SUB);
        chk("sub_err", err, 1);
        chk("sub_pop", pop, 0);
        chk("sub_write", write, 0);
        release_key();
        press(K_ADD);
        chk("add_ignored_in_err", write, 0);
        release_key();
        press(K_CLR);
        chk("clr2_write", write, 1);
        chk("clr2_nv", new_value, 0);
        chk("clr2_err", err, 0);
        release_key();

        // add then sub directly (code-to-code edge)
        next = 9; top = 7;
        press(K_ADD);
        chk("add_pop", pop, 1);
        chk("add_nv", new_value, 16);
        press(K_SUB);
        chk("sub_write", write, 1);
        chk("sub_nv", new_value, 2);
        release_key();

        // divide 100/7, operands changed and key pressed mid-divide
        next = 100; top = 7;
        press(K_DIV);
        chk("div_busy_first", busy, 1);
        next = 5; top = 1;
        n = 1; stray = 0;
        for (int i = 1; i < 32; i++) begin
            if (i == 10) pressed = K_ADD;
            tick();
            if (busy) n++;
            if (pop || write || push) stray++;
        end
        chk("div_busy_cycles", n, 32);
        chk("div_stray_pulses", stray, 0);
        tick();
        chk("div_done_busy", busy, 0);
        chk("div_done_pop", pop, 1);
        chk("div_done_write", write, 1);
        chk("div_quotient", new_value, 14);
        tick();
        chk("div_pulse_width", {pop, write}, 0);
        release_key();

        // multiply overflow, clear, multiply in range
        count = 2; next = 32'h10000; top = 32'h10000;
        press(K_MUL);
        chk("mul_ovf_err", err, 1);
        chk("mul_ovf_pulses", {pop, write}, 0);
        release_key();
        press(K_CLR);
        release_key();
        top = 32'h100;
        press(K_MUL);
        chk("mul_pulses", {pop, write}, 2'b11);
        chk("mul_nv", new_value, 32'h1000000);
        release_key();

        // push: normal and full
        count = 5;
        press(K_PSH);
        chk("push_ok", push, 1);
        release_key();
        count = D;
        press(K_PSH);
        chk("push_full_err", err, 1);
        chk("push_full_push", push, 0);
        release_key();
        press(K_CLR);
        release_key();

        // add carry-out
        count = 2; next = 32'hFFFF_FFFF; top = 1;
        press(K_ADD);
        chk("add_carry_err", err, 1);
        release_key();
        press(K_CLR);
        release_key();

        // leave a nonzero value, then reset mid-divide
        next = 3; top = 4;
        press(K_ADD);
        chk("add_nv2", new_value, 7);
        release_key();
        next = 100; top = 7;
        press(K_DIV);
        repeat (5) tick();
        chk("div2_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_nv", new_value, 0);
        chk("arst_pulses", {push, pop, write, err}, 0);
        pressed = '0;
        tick();
        reset = 1'b1;
        stray = 0;
        repeat (40) begin tick(); if (pop || write || busy) stray++; end
        chk("abort_no_pulses", stray, 0);
        next = 9; top = 4;
        press(K_SUB);
        chk("idle_after_reset", new_value, 5);
        release_key();

        // radix 16 instance
        count_h = 1; top_h = 32'hF;
        pressed_h = K_3;
        tick();
        chk("hex_write", write_h, 1);
        chk("hex_nv", new_value_h, 32'hF3);
        pressed_h = '0;
        tick();
        top_h = 32'hFFFF_FFFF;
        pressed_h = K_1;
        tick();
        chk("hex_ovf_err", err_h, 1);
        chk("hex_ovf_write", write_h, 0);
        pressed_h = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
